// File: rtl/rf_trace_monitor.sv
// Run monitor: shadow register file, run/write counters, end-PC/timeout detection, heartbeat.
// Define RF_TRACE_FIFO_EN to build the show-ahead write-trace FIFO; otherwise trace outputs are tied low.
module rf_trace_monitor #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned PC_WIDTH   = 12,
    parameter int unsigned CYC_WIDTH  = 32,
    parameter int unsigned HEARTBEAT  = 100,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CYC_WIDTH-1:0]  max_cycles,
    input  logic [PC_WIDTH-1:0]   end_pc,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic                  pc_valid,
    input  logic                  rf_we,
    input  logic [ADDR_WIDTH-1:0] rf_waddr,
    input  logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic [1:0]            state,
    output logic                  done,
    output logic                  timeout,
    output logic [CYC_WIDTH-1:0]  cycle_count,
    output logic [CYC_WIDTH-1:0]  write_count,
    output logic                  heartbeat,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [ADDR_WIDTH-1:0] trace_addr,
    output logic [DATA_WIDTH-1:0] trace_data,
    output logic                  trace_overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_DONE    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic                  run, restart, wr_ok, dump_ok;
    logic [CYC_WIDTH-1:0]  cycle_next;
    logic [DATA_WIDTH-1:0] shadow [NUM_REGS];

    assign run        = (state_q == ST_RUN);
    assign restart    = start && !run;
    assign cycle_next = cycle_count + 1'b1;
    assign wr_ok      = run && rf_we && (rf_waddr != '0) && ({1'b0, rf_waddr} < REG_LIMIT);
    assign dump_ok    = (dump_addr != '0) && ({1'b0, dump_addr} < REG_LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (pc_valid && pc == end_pc)
                    state_d = ST_DONE;
                else if (max_cycles != '0 && cycle_next == max_cycles)
                    state_d = ST_TIMEOUT;
            end
            default: if (start) state_d = ST_RUN;
        endcase
    end

    always_comb begin
        state   = state_q;
        done    = (state_q == ST_DONE);
        timeout = (state_q == ST_TIMEOUT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            write_count <= '0;
        end else if (restart) begin
            cycle_count <= '0;
            write_count <= '0;
        end else if (run) begin
            cycle_count <= cycle_next;
            if (wr_ok) write_count <= write_count + 1'b1;
        end
    end

    // dump_data samples the shadow before this edge's write lands (read-before-write).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow    <= '{default: '0};
            dump_data <= '0;
        end else begin
            dump_data <= dump_ok ? shadow[dump_addr] : '0;
            if (restart)    shadow <= '{default: '0};
            else if (wr_ok) shadow[rf_waddr] <= rf_wdata;
        end
    end

    generate
        if (HEARTBEAT == 0) begin : g_no_hb
            assign heartbeat = 1'b0;
        end else begin : g_hb
            localparam int unsigned HB_W = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
            logic [HB_W-1:0] hb_cnt;
            logic            hb_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    hb_cnt <= '0;
                    hb_q   <= 1'b0;
                end else if (restart) begin
                    hb_cnt <= '0;
                    hb_q   <= 1'b0;
                end else if (run) begin
                    if (hb_cnt == HB_W'(HEARTBEAT - 1)) begin
                        hb_cnt <= '0;
                        hb_q   <= 1'b1;
                    end else begin
                        hb_cnt <= hb_cnt + 1'b1;
                        hb_q   <= 1'b0;
                    end
                end else begin
                    hb_q <= 1'b0;
                end
            end

            assign heartbeat = hb_q;
        end
    endgenerate

`ifdef RF_TRACE_FIFO_EN
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
    logic [PTR_W:0]                   fifo_cnt;
    logic                             ovf_q, fifo_full, pop, push_ok;

    assign fifo_full = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign pop       = trace_valid && trace_ready;
    assign push_ok   = wr_ok && (!fifo_full || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_mem <= '{default: '0};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (restart) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) begin
                fifo_mem[wr_ptr] <= {rf_waddr, rf_wdata};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (wr_ok && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    assign trace_valid               = (fifo_cnt != '0);
    assign {trace_addr, trace_data}  = fifo_mem[rd_ptr];
    assign trace_overflow            = ovf_q;
`else
    logic             unused_trace_ready;
    logic [PTR_W-1:0] unused_fifo_ptr;

    assign unused_trace_ready = trace_ready;
    assign unused_fifo_ptr    = '0;
    assign trace_valid        = 1'b0;
    assign trace_addr         = '0;
    assign trace_data         = '0;
    assign trace_overflow     = 1'b0;
`endif

endmodule
